lcd_fb_arbiter: RTL and testbench
=================================

# lcd_fb_arbiter

Single-port framebuffer arbiter between the scan-out path (`lcd_sync` read request) and a drawing-engine write port, on the `clk_lcd` domain. Display reads have absolute, zero-wait priority so the panel never underflows. Writes are buffered in a small FIFO and drained into the RAM during blanking or any other cycle without a display read. A starvation monitor flags a writer that is blocked for too long.

## Interface
Parameters:
- `AW`, 16, RAM address width (matches `lcd_rdaddr`)
- `DW`, 16, pixel/RAM data width (RGB565)
- `FIFO_DEPTH`, 4, write-buffer entries, power of two, 2..16
- `STARVE_MAX`, 1024, consecutive blocked-write cycles before `wr_starved` sets

Ports:
- `clk` in 1: LCD pixel clock; single clock domain
- `rest` in 1: reset, synchronous, active-high
- `disp_rden` in 1: display read request (lcd_sync `img_ack`)
- `disp_addr` in AW: display read address
- `disp_data` out DW: read data
- `disp_vld` out 1: `disp_data` valid
- `wr_valid` in 1: writer request
- `wr_ready` out 1: FIFO can accept
- `wr_addr` in AW, `wr_data` in DW: write address/data
- `ram_en`, `ram_we` out 1: RAM strobe / write enable
- `ram_addr` out AW, `ram_wdata` out DW, `ram_rdata` in DW: synchronous single-port RAM, 1-cycle read latency
- `grant` out 2: last-cycle grant, 0=IDLE 1=DISP 2=WRITE
- `wr_starved` out 1: sticky starvation flag
- `starve_clr` in 1: clears `wr_starved`
- `stat_wr_cnt`, `stat_blk_cnt` out 16: statistics (see Configuration)

## Operation
- Write push: `wr_valid && wr_ready` stores {addr,data}. `wr_ready = !full`. No push-bypass: a full FIFO refuses a push even when a pop occurs in the same cycle.
- Per-cycle grant, combinational to RAM pins:
  - DISP: `disp_rden=1`. `ram_en=1`, `ram_we=0`, `ram_addr=disp_addr`.
  - WRITE: `disp_rden=0` and FIFO not empty. Pop the head; `ram_en=1`, `ram_we=1`, addr/wdata from head.
  - IDLE: `ram_en=0`, `ram_we=0`, `ram_addr`/`ram_wdata` hold the last driven value.
- `grant` register holds the state of the previous cycle: IDLE/DISP/WRITE, transitions free each cycle by the rules above.
- No forwarding: a display read of an address with a write still pending in the FIFO returns old RAM contents.
- Starvation counter, width clog2(STARVE_MAX)+1:
  - Increments while `wr_valid && !wr_ready`; resets to 0 otherwise.
  - On reaching STARVE_MAX it saturates and sets `wr_starved`.
  - `starve_clr` clears the flag; if clear and set coincide, the set wins.

## Timing
- Read latency is 1: `disp_vld(N+1) = disp_rden(N)`. `disp_data(N+1) = ram_rdata` is passed through combinationally, not re-registered.
- Write: pushed in cycle N, earliest RAM write in cycle N+1, which requires `disp_rden=0` in N+1.
- Back-to-back pops are allowed: one per non-display cycle.
- Reset values:
  - FIFO empty, `wr_ready=1` (also during reset)
  - `grant=0`, `disp_vld=0`, `wr_starved=0`, counters 0
  - `ram_addr`, `ram_wdata` = 0
  - `ram_en` and `ram_we` are forced to 0 while `rest` is high, regardless of other inputs.
- Reset mid-operation discards FIFO contents. Writes lost this way are not reported.

## Configuration
- `LCD_FB_ARB_STATS_EN` defined:
  - `stat_wr_cnt` counts RAM writes performed.
  - `stat_blk_cnt` counts cycles with `wr_valid && !wr_ready`.
  - Both saturate at 16'hFFFF and clear on `rest`.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Shared package `lcd_pkg`:
  - grant encodings `GNT_IDLE`, `GNT_DISP`, `GNT_WRITE`
  - default AW/DW constants shared with `lcd_sync`
- Sub-module `lcd_fb_wfifo`: synchronous FIFO of width AW+DW with depth FIFO_DEPTH and full/empty flags, reusable elsewhere.
- Arbiter, starvation monitor and statistics live in `lcd_fb_arbiter`.

## Test plan
- Reset: hold `rest` 3 cycles while `disp_rden=1` -> `ram_en=0`, `wr_ready=1`, `grant=0`, `disp_vld=0` throughout.
- Pure scan: `disp_rden=1` for addr 0..799, RAM preloaded data=addr -> `disp_vld` is high in cycles 1..800 with `disp_data`=0..799 in order; `ram_we` never asserts.
- Blanking drain:
  - Stimulus: push 4 writes (addr 10..13, data 16'hA000+i) during `disp_rden=1`, then drop `disp_rden`.
  - Response: `wr_ready=0` after the 4th push. RAM writes occur on the 4 consecutive cycles after `disp_rden` falls, in FIFO order, with `grant=2` on each.
- Full-plus-pop: FIFO full, `wr_valid=1`, `disp_rden=0` -> the pop happens that cycle, the push is refused, and the push is accepted the next cycle.
- Starvation: STARVE_MAX=8, FIFO full, `disp_rden=1`, `wr_valid=1` -> `wr_starved` rises after the 8th blocked cycle. `starve_clr` while still blocked -> flag stays 1 (set wins).
- Stats (macro defined): 5 drained writes plus 12 blocked cycles -> `stat_wr_cnt=5`, `stat_blk_cnt=12`. Macro undefined -> both read 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: constants and grant encodings shared by the LCD framebuffer blocks.
// Contents:
//   LCD_AW / LCD_DW  default framebuffer address / pixel widths (also used by lcd_sync)
//   gnt_e            per-cycle RAM grant: idle, display read, buffered write
package lcd_pkg;
    localparam int LCD_AW = 16;
    localparam int LCD_DW = 16;
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_DISP  = 2'd1,
        GNT_WRITE = 2'd2
    } gnt_e;
endpackage

// File: rtl/lcd_fb_wfifo.sv
// lcd_fb_wfifo: synchronous FIFO with full/empty flags and a combinational head.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  store wdata unless full (a same-cycle pop does not make room)
//   pop          drop the head unless empty
//   rdata        current head entry
//   full, empty  occupancy flags
module lcd_fb_wfifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [PW:0]  wp_q, wp_d, rp_q, rp_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
        empty = wp_q == rp_q;
        rdata = mem_q[rp_q[PW-1:0]];
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (push && !full) begin
            mem_d[wp_q[PW-1:0]] = wdata;
            wp_d = wp_q + 1'b1;
        end
        if (pop && !empty) rp_d = rp_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/lcd_fb_arbiter.sv
// lcd_fb_arbiter: single-port framebuffer arbiter, display reads first, buffered writes drained in gaps.
// Ports:
//   clk, rest                         pixel clock, synchronous active-high reset
//   disp_rden, disp_addr              display read request/address (always wins the RAM)
//   disp_data, disp_vld               read data one cycle after the request
//   wr_valid, wr_ready, wr_addr/data  drawing-engine write port into the FIFO
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata              synchronous single-port RAM, 1-cycle read latency
//   grant                             previous cycle's grant (0 idle, 1 display, 2 write)
//   wr_starved, starve_clr            sticky starvation flag and its clear (set wins)
//   stat_wr_cnt, stat_blk_cnt         RAM writes / blocked-write cycles, built only when
//                                     LCD_FB_ARB_STATS_EN is defined, otherwise tied to 0
module lcd_fb_arbiter
    import lcd_pkg::*;
#(
    parameter int AW         = LCD_AW,
    parameter int DW         = LCD_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 1024
) (
    input  logic          clk,
    input  logic          rest,
    input  logic          disp_rden,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic          disp_vld,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    grant,
    output logic          wr_starved,
    input  logic          starve_clr,
    output logic [15:0]   stat_wr_cnt,
    output logic [15:0]   stat_blk_cnt
);
    localparam int            SW   = $clog2(STARVE_MAX) + 1;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic               full, empty, pop, blocked;
    logic [AW+DW-1:0]   head;
    gnt_e               gnt_d, gnt_q;
    logic [AW-1:0]      addr_d, addr_q;
    logic [DW-1:0]      wdata_d, wdata_q;
    logic               vld_q;
    logic [SW-1:0]      cnt_d, cnt_q;
    logic               starved_d, starved_q;

    lcd_fb_wfifo #(.W(AW + DW), .DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk   (clk),
        .rst   (rest),
        .push  (wr_valid && wr_ready),
        .pop   (pop),
        .wdata ({wr_addr, wr_data}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Address/data lines keep their last driven value on idle cycles.
    always_comb begin
        gnt_d     = rest ? GNT_IDLE : disp_rden ? GNT_DISP : !empty ? GNT_WRITE : GNT_IDLE;
        pop       = gnt_d == GNT_WRITE;
        addr_d    = gnt_d == GNT_DISP ? disp_addr : pop ? head[AW+DW-1:DW] : addr_q;
        wdata_d   = pop ? head[DW-1:0] : wdata_q;
        ram_en    = gnt_d != GNT_IDLE;
        ram_we    = pop;
        ram_addr  = rest ? '0 : addr_d;
        ram_wdata = rest ? '0 : wdata_d;
        wr_ready  = rest || !full;
        blocked   = wr_valid && !wr_ready;
        cnt_d     = !blocked ? '0 : cnt_q == SMAX ? cnt_q : cnt_q + 1'b1;
        // Set has priority over clear, so a still-blocked writer keeps the flag up.
        starved_d = (blocked && cnt_d == SMAX) || (starved_q && !starve_clr);
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            gnt_q     <= GNT_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            vld_q     <= 1'b0;
            cnt_q     <= '0;
            starved_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            vld_q     <= disp_rden;
            cnt_q     <= cnt_d;
            starved_q <= starved_d;
        end
    end

    assign grant      = gnt_q;
    assign disp_vld   = vld_q;
    assign disp_data  = ram_rdata;
    assign wr_starved = starved_q;

`ifdef LCD_FB_ARB_STATS_EN
    logic [15:0] wr_cnt_d, wr_cnt_q, blk_cnt_d, blk_cnt_q;

    always_comb begin
        wr_cnt_d  = wr_cnt_q + {15'd0, pop && wr_cnt_q != 16'hFFFF};
        blk_cnt_d = blk_cnt_q + {15'd0, blocked && blk_cnt_q != 16'hFFFF};
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            wr_cnt_q  <= '0;
            blk_cnt_q <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_blk_cnt = blk_cnt_q;
`else
    assign stat_wr_cnt  = '0;
    assign stat_blk_cnt = '0;
`endif
endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// tb_lcd_fb_arbiter: queue-based model checked every cycle, plus directed literal checks.
module tb_lcd_fb_arbiter;
    localparam int SMAX = 8;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        disp_rden = 1'b1;
    logic [15:0] disp_addr = '0;
    logic [15:0] disp_data;
    logic        disp_vld;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic [1:0]  grant;
    logic        wr_starved;
    logic        starve_clr = 1'b0;
    logic [15:0] stat_wr_cnt, stat_blk_cnt;

    int n_chk = 0;
    int n_fail = 0;

    lcd_fb_arbiter #(.AW(16), .DW(16), .FIFO_DEPTH(4), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rest(rest), .disp_rden(disp_rden), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_vld(disp_vld), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .grant(grant), .wr_starved(wr_starved),
        .starve_clr(starve_clr), .stat_wr_cnt(stat_wr_cnt), .stat_blk_cnt(stat_blk_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] ram    [65536];
    logic [15:0] shadow [65536];

    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else ram_rdata <= ram[ram_addr];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: pending writes as a queue, plus plain counters/flags.
    logic [31:0] m_q [$];
    logic [1:0]  m_grant = 0;
    logic        m_vld = 0, m_starved = 0, m_full, m_blocked;
    logic [15:0] m_rd_addr = 0, m_last_addr = 0, m_last_wdata = 0, e_addr, e_wd;
    int          m_cnt = 0, m_wr = 0, m_blk = 0, g;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("grant", grant, m_grant);
            chk("disp_vld", disp_vld, m_vld);
            if (m_vld) chk("disp_data", disp_data, shadow[m_rd_addr]);
            chk("wr_starved", wr_starved, m_starved);
`ifdef LCD_FB_ARB_STATS_EN
            chk("stat_wr_cnt", stat_wr_cnt, m_wr);
            chk("stat_blk_cnt", stat_blk_cnt, m_blk);
`else
            chk("stat_wr_cnt", stat_wr_cnt, 0);
            chk("stat_blk_cnt", stat_blk_cnt, 0);
`endif
            if (rest) begin
                chk("rst_ram_en", ram_en, 0);
                chk("rst_ram_we", ram_we, 0);
                chk("rst_wr_ready", wr_ready, 1);
                chk("rst_ram_addr", ram_addr, 0);
                chk("rst_ram_wdata", ram_wdata, 0);
                m_q.delete();
                m_grant = 0; m_vld = 0; m_starved = 0; m_cnt = 0; m_wr = 0; m_blk = 0;
                m_last_addr = 0; m_last_wdata = 0;
            end else begin
                m_full = m_q.size() == 4;
                if (disp_rden) begin
                    g = 1; e_addr = disp_addr; e_wd = m_last_wdata;
                end else if (m_q.size() > 0) begin
                    g = 2; e_addr = m_q[0][31:16]; e_wd = m_q[0][15:0];
                end else begin
                    g = 0; e_addr = m_last_addr; e_wd = m_last_wdata;
                end
                chk("wr_ready", wr_ready, !m_full);
                chk("ram_en", ram_en, g != 0);
                chk("ram_we", ram_we, g == 2);
                chk("ram_addr", ram_addr, e_addr);
                chk("ram_wdata", ram_wdata, e_wd);
                m_blocked = wr_valid && m_full;
                if (g == 2) begin
                    shadow[e_addr] = e_wd;
                    void'(m_q.pop_front());
                    if (m_wr < 16'hFFFF) m_wr++;
                end
                if (wr_valid && !m_full) m_q.push_back({wr_addr, wr_data});
                m_last_addr = e_addr; m_last_wdata = e_wd;
                m_rd_addr = disp_addr; m_vld = disp_rden; m_grant = 2'(g);
                m_cnt = m_blocked ? (m_cnt < SMAX ? m_cnt + 1 : SMAX) : 0;
                if (m_blocked && m_cnt == SMAX) m_starved = 1;
                else if (starve_clr) m_starved = 0;
                if (m_blocked && m_blk < 16'hFFFF) m_blk++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [15:0] base, input logic [15:0] dbase);
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_valid = 1; wr_addr = base + 16'(i); wr_data = dbase + 16'(i);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 16'(i);
            shadow[i] = 16'(i);
        end
        // Reset held 3 cycles with a display request present.
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("reset_ram_en", ram_en, 0);
            chk("reset_wr_ready", wr_ready, 1);
            chk("reset_grant", grant, 0);
            chk("reset_disp_vld", disp_vld, 0);
        end
        // Pure scan of 800 pixels.
        for (int i = 0; i < 800; i++) begin
            tick();
            rest = 0; disp_rden = 1; disp_addr = 16'(i);
            if (i == 100) begin
                #1;
                chk("scan_vld", disp_vld, 1);
                chk("scan_data", disp_data, 99);
            end
        end
        // Blanking drain: pushes during reads of addr 10 (old data expected), then drain.
        disp_addr = 10;
        push4(10, 16'hA000);
        tick();
        wr_valid = 0; disp_rden = 0;
        #1 chk("drain_full", wr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_we", ram_we, 1);
            chk("drain_addr", ram_addr, 10 + i);
            chk("drain_wdata", ram_wdata, 16'hA000 + i);
            tick();
            #1 chk("drain_grant", grant, 2);
        end
        chk("drain_done", ram_we, 0);
        disp_rden = 1; disp_addr = 10;
        tick();
        disp_rden = 0;
        #1 chk("drain_readback", disp_data, 16'hA000);
        // Full FIFO with a pop in the same cycle still refuses the push.
        disp_rden = 1; disp_addr = 0;
        push4(20, 16'hB020);
        tick();
        disp_rden = 0; wr_valid = 1; wr_addr = 24; wr_data = 16'hB024;
        #1;
        chk("fpp_ready0", wr_ready, 0);
        chk("fpp_pop_we", ram_we, 1);
        chk("fpp_pop_addr", ram_addr, 20);
        tick(); #1;
        chk("fpp_ready1", wr_ready, 1);
        chk("fpp_pop2_addr", ram_addr, 21);
        tick();
        wr_valid = 0;
        repeat (3) tick();
        disp_rden = 1; disp_addr = 24;
        tick();
        disp_rden = 0;
        #1 chk("fpp_readback", disp_data, 16'hB024);
        // Starvation with STARVE_MAX=8.
        disp_rden = 1; disp_addr = 0;
        push4(30, 16'hC030);
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1 chk("starve_edge", wr_starved, k == 8);
        end
        starve_clr = 1;
        tick();
        #1 chk("starve_set_wins", wr_starved, 1);
        wr_valid = 0;
        tick();
        #1 chk("starve_cleared", wr_starved, 0);
        starve_clr = 0; disp_rden = 0;
        repeat (5) tick();
        // Statistics after a fresh reset: 12 blocked cycles, 5 RAM writes.
        rest = 1;
        tick();
        rest = 0; disp_rden = 1;
        push4(40, 16'hD040);
        repeat (13) tick();
        wr_valid = 0; disp_rden = 0;
        repeat (4) tick();
        wr_valid = 1; wr_addr = 44; wr_data = 16'hD044;
        tick();
        wr_valid = 0;
        repeat (3) tick();
        #1;
`ifdef LCD_FB_ARB_STATS_EN
        chk("stats_wr", stat_wr_cnt, 5);
        chk("stats_blk", stat_blk_cnt, 12);
`else
        chk("stats_wr_off", stat_wr_cnt, 0);
        chk("stats_blk_off", stat_blk_cnt, 0);
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
